uart_frame_parser: RTL and testbench

UART_FRAME_PARSER -- requirements
Module: uart_frame_parser

---
 rtl/uart_frame_parser.sv | 189 ++++++++++++++++++
 tb/tb_uart_frame_parser.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_parser.sv
// Byte-stream frame parser: HDR, ADDR, LEN, DATA[N] (, CSUM) -> burst of N RAM writes.
// Define UART_FRAME_PARSER_CHECKSUM_EN to require a trailing XOR checksum byte.
module uart_frame_parser #(
    parameter int         MAX_LEN     = 16,
    parameter int         TIMEOUT_CYC = 500000,
    parameter logic [7:0] HDR         = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    output logic       wr,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy,
    output logic       frame_ok,
    output logic       frame_err
);

    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

`ifdef UART_FRAME_PARSER_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, ADDR, LEN, DATA, CSUM, COMMIT} state_t;
`else
    typedef enum logic [2:0] {IDLE, ADDR, LEN, DATA, COMMIT} state_t;
`endif

    state_t          state, state_n;
    logic [7:0]      base;
    logic [LW-1:0]   len;
    logic [LW-1:0]   idx;    // fill index in DATA, write index in COMMIT
    logic [TW-1:0]   tmo;
    logic [7:0]      data_buf [MAX_LEN];
`ifdef UART_FRAME_PARSER_CHECKSUM_EN
    logic [7:0]      csum;
`endif

    logic in_frame;
    logic start_commit;
    logic ok_n;
    logic err_n;
    logic last_data;

    assign busy      = (state != IDLE);
    assign last_data = ((idx + LW'(1)) == len);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n      = state;
        in_frame     = 1'b0;
        start_commit = 1'b0;
        ok_n         = 1'b0;
        err_n        = 1'b0;
        case (state)
            IDLE: begin
                if (byte_valid && byte_in == HDR) state_n = ADDR;
            end
            ADDR: begin
                in_frame = 1'b1;
                if (byte_valid) state_n = LEN;
            end
            LEN: begin
                in_frame = 1'b1;
                if (byte_valid) begin
                    if (byte_in == 8'd0 || byte_in > 8'(MAX_LEN)) begin
                        err_n   = 1'b1;
                        state_n = IDLE;
                    end else begin
                        state_n = DATA;
                    end
                end
            end
            DATA: begin
                in_frame = 1'b1;
                if (byte_valid && last_data) begin
`ifdef UART_FRAME_PARSER_CHECKSUM_EN
                    state_n = CSUM;
`else
                    state_n      = COMMIT;
                    start_commit = 1'b1;
`endif
                end
            end
`ifdef UART_FRAME_PARSER_CHECKSUM_EN
            CSUM: begin
                in_frame = 1'b1;
                if (byte_valid) begin
                    if (byte_in == csum) begin
                        state_n      = COMMIT;
                        start_commit = 1'b1;
                    end else begin
                        err_n   = 1'b1;
                        state_n = IDLE;
                    end
                end
            end
`endif
            COMMIT: begin
                if (idx == len) begin
                    ok_n    = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        // A byte arriving on the expiry cycle keeps the frame alive.
        if (in_frame && !byte_valid && tmo == TW'(TIMEOUT_CYC - 1)) begin
            err_n   = 1'b1;
            state_n = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr        <= 1'b0;
            wr_addr   <= 8'd0;
            wr_data   <= 8'd0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            tmo       <= '0;
            idx       <= '0;
            base      <= 8'd0;
            len       <= '0;
`ifdef UART_FRAME_PARSER_CHECKSUM_EN
            csum      <= 8'd0;
`endif
        end else begin
            wr        <= 1'b0;
            frame_ok  <= ok_n;
            frame_err <= err_n;
            if (byte_valid || !in_frame) tmo <= '0;
            else                         tmo <= tmo + TW'(1);
            case (state)
                ADDR: if (byte_valid) begin
                    base <= byte_in;
`ifdef UART_FRAME_PARSER_CHECKSUM_EN
                    csum <= byte_in;
`endif
                end
                LEN: if (byte_valid) begin
                    len <= byte_in[LW-1:0];
                    idx <= '0;
`ifdef UART_FRAME_PARSER_CHECKSUM_EN
                    csum <= csum ^ byte_in;
`endif
                end
                DATA: if (byte_valid) begin
                    idx <= idx + LW'(1);
`ifdef UART_FRAME_PARSER_CHECKSUM_EN
                    csum <= csum ^ byte_in;
`endif
                end
                COMMIT: begin
                    if (idx != len) begin
                        wr      <= 1'b1;
                        wr_addr <= base + 8'(idx);
                        wr_data <= data_buf[idx[IW-1:0]];
                        idx     <= idx + LW'(1);
                    end else begin
                        idx <= '0;
                    end
                end
                default: ;
            endcase
            // First write issues on the accepting edge; later ones come from COMMIT.
            if (start_commit) begin
                wr      <= 1'b1;
                wr_addr <= base;
`ifdef UART_FRAME_PARSER_CHECKSUM_EN
                wr_data <= data_buf[0];
`else
                wr_data <= (idx == '0) ? byte_in : data_buf[0];
`endif
                idx     <= LW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == DATA && byte_valid) data_buf[idx[IW-1:0]] <= byte_in;
    end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Scoreboard bench for uart_frame_parser: stimulus pushes expected events, a monitor pops them.
module tb_uart_frame_parser;

    localparam int MAX_LEN = 16;
    localparam int TMO     = 100;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       byte_valid = 1'b0;
    logic [7:0] byte_in = 8'd0;
    logic       wr, busy, frame_ok, frame_err;
    logic [7:0] wr_addr, wr_data;

    uart_frame_parser #(.MAX_LEN(MAX_LEN), .TIMEOUT_CYC(TMO), .HDR(8'hA5)) dut (
        .clk(clk), .rst_n(rst_n), .byte_in(byte_in), .byte_valid(byte_valid),
        .wr(wr), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
        .frame_ok(frame_ok), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // kind: 0 = write, 1 = frame_ok, 2 = frame_err; at = cycle stamp it must appear on
    typedef struct {
        int         kind;
        logic [7:0] addr;
        logic [7:0] data;
        int         at;
    } ev_t;

    ev_t        exp_q[$];
    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] fd [17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int kind, input logic [7:0] a, input logic [7:0] d, input int at);
        ev_t e;
        e.kind = kind; e.addr = a; e.data = d; e.at = at;
        exp_q.push_back(e);
    endtask

    task automatic monitor_step();
        ev_t e;
        int  kind;
        if (wr === 1'b1 || frame_ok === 1'b1 || frame_err === 1'b1) begin
            check("exclusive strobes",
                  32'({wr, frame_ok, frame_err} inside {3'b100, 3'b010, 3'b001}), 32'd1);
            kind = (wr === 1'b1) ? 0 : (frame_ok === 1'b1) ? 1 : 2;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected event: kind %0d at cycle %0d, expected none", kind, cyc);
            end else begin
                e = exp_q.pop_front();
                check("event kind", 32'(kind), 32'(e.kind));
                check("event cycle", 32'(cyc), 32'(e.at));
                if (kind == 0) begin
                    check("wr_addr", 32'(wr_addr), 32'(e.addr));
                    check("wr_data", 32'(wr_data), 32'(e.data));
                end
            end
        end
    endtask

    task automatic idle(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, output int acc);
        byte_in    = b;
        byte_valid = 1'b1;
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
        acc        = cyc;
    endtask

    // Sends HDR, base, n, fd[0..n-1] and, with checksum enabled, fd[n] as the checksum.
    task automatic send_frame(input logic [7:0] base, input int n, output int acc);
        send_byte(8'hA5, acc);
        send_byte(base, acc);
        send_byte(8'(n), acc);
        for (int i = 0; i < n; i++) send_byte(fd[i], acc);
`ifdef UART_FRAME_PARSER_CHECKSUM_EN
        send_byte(fd[n], acc);
`endif
    endtask

    task automatic expect_commit(input logic [7:0] base, input int n, input int acc);
        for (int i = 0; i < n; i++) push(0, base + 8'(i), fd[i], acc + i);
        push(1, 8'd0, 8'd0, acc + n);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " wr"},        32'(wr),        32'd0);
        check({tag, " wr_addr"},   32'(wr_addr),   32'd0);
        check({tag, " wr_data"},   32'(wr_data),   32'd0);
        check({tag, " busy"},      32'(busy),      32'd0);
        check({tag, " frame_ok"},  32'(frame_ok),  32'd0);
        check({tag, " frame_err"}, 32'(frame_err), 32'd0);
    endtask

    task automatic frame_a(); // A5,10,03,11,22,33 (,13)
        int acc;
        fd[0] = 8'h11; fd[1] = 8'h22; fd[2] = 8'h33; fd[3] = 8'h13;
        send_frame(8'h10, 3, acc);
        expect_commit(8'h10, 3, acc);
        idle(8);
    endtask

    initial begin
        int acc;
        int spin;
        fork
            forever begin
                @(negedge clk);
                monitor_step();
            end
        join_none

        rst_n = 1'b0;
        idle(3);
        check_all_zero("reset");
        rst_n = 1'b1;

        // Non-header bytes in IDLE are ignored silently
        send_byte(8'h00, acc);
        send_byte(8'h5A, acc);
        send_byte(8'h13, acc);
        idle(3);
        check("idle noise busy", 32'(busy), 32'd0);

        frame_a();

        // Header value inside a frame is plain data
        fd[0] = 8'hA5; fd[1] = 8'hA5; fd[2] = 8'h42;
        send_frame(8'h40, 2, acc);
        expect_commit(8'h40, 2, acc);
        idle(6);

        // Address wrap, plus a byte arriving mid-commit that must be dropped
        fd[0] = 8'h01; fd[1] = 8'h02; fd[2] = 8'h03; fd[3] = 8'h04; fd[4] = 8'hFE;
        send_frame(8'hFE, 4, acc);
        expect_commit(8'hFE, 4, acc);
        send_byte(8'hA5, acc);
        idle(8);
        check("after wrap busy", 32'(busy), 32'd0);

`ifdef UART_FRAME_PARSER_CHECKSUM_EN
        fd[0] = 8'h11; fd[1] = 8'h22; fd[2] = 8'h33; fd[3] = 8'h14;
        send_frame(8'h10, 3, acc);
        push(2, 8'd0, 8'd0, acc);
        idle(2);
        check("bad csum busy", 32'(busy), 32'd0);
        idle(4);
`endif

        // Length bounds
        send_byte(8'hA5, acc); send_byte(8'h20, acc); send_byte(8'h00, acc);
        push(2, 8'd0, 8'd0, acc);
        idle(2);
        check("len0 busy", 32'(busy), 32'd0);
        send_byte(8'hA5, acc); send_byte(8'h20, acc); send_byte(8'h11, acc);
        push(2, 8'd0, 8'd0, acc);
        idle(2);
        check("len17 busy", 32'(busy), 32'd0);

        // N = MAX_LEN: data 00..0F XOR to 0, so checksum = 80^10 = 90
        for (int i = 0; i < 16; i++) fd[i] = 8'(i);
        fd[16] = 8'h90;
        send_frame(8'h80, 16, acc);
        expect_commit(8'h80, 16, acc);
        idle(22);

        // Timeout 100 clocks after the last byte
        send_byte(8'hA5, acc); send_byte(8'h20, acc); send_byte(8'h02, acc);
        send_byte(8'h55, acc);
        push(2, 8'd0, 8'd0, acc + TMO);
        idle(TMO - 1);
        check("pre-timeout busy", 32'(busy), 32'd1);
        idle(3);
        check("post-timeout busy", 32'(busy), 32'd0);
        frame_a();

        // A byte on the expiry cycle wins over the timeout
        send_byte(8'hA5, acc); send_byte(8'h30, acc); send_byte(8'h01, acc);
        idle(TMO - 1);
        send_byte(8'h77, acc);
`ifdef UART_FRAME_PARSER_CHECKSUM_EN
        send_byte(8'h46, acc);
`endif
        fd[0] = 8'h77;
        expect_commit(8'h30, 1, acc);
        idle(5);

        // Reset during the 2nd of 4 commit writes
        fd[0] = 8'h01; fd[1] = 8'h02; fd[2] = 8'h03; fd[3] = 8'h04; fd[4] = 8'h60;
        send_frame(8'h60, 4, acc);
        push(0, 8'h60, 8'h01, acc);
        push(0, 8'h61, 8'h02, acc + 1);
        idle(1);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        check_all_zero("commit reset");
        idle(8);

        frame_a();

        spin = 0;
        while (exp_q.size() != 0 && spin < 50) begin
            idle(1);
            spin++;
        end
        check("pending expected events", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
